// File: rtl/lockable_reg_bank_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lockable_reg_pkg : lock-mode encoding and per-register mode lookup    |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package lockable_reg_pkg;

  localparam int MODE_W         = 2;
  localparam int MODE_VEC_MAX_W = 64;

  typedef enum logic [MODE_W-1:0] {
    MODE_FREE = 2'b00,
    MODE_ONCE = 2'b01,
    MODE_BIT  = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  // Callers zero-extend their mode vector to MODE_VEC_MAX_W bits.
  function automatic mode_e mode_of(input logic [MODE_VEC_MAX_W-1:0] mode_vec, input int idx);
    return mode_e'(mode_vec[MODE_W*idx +: MODE_W]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lockable_reg_bank_cell.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lock_reg_cell : one protected register with its sticky lock flag      |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module lock_reg_cell
  import lockable_reg_pkg::*;
#(
  parameter int    DATA_W   = 16,
  parameter int    LOCK_BIT = 0,
  parameter mode_e MODE     = MODE_FREE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_accept,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] reg_value,
  output logic              locked
);

  logic [DATA_W-1:0] value_q, value_d;
  logic              lock_q, lock_d;
  logic              lock_req;

  always_comb begin
    lock_req = 1'b0;
    case (MODE)
      MODE_ONCE: lock_req = 1'b1;
      MODE_BIT:  lock_req = wr_data[LOCK_BIT];
      default:   lock_req = 1'b0;
    endcase
  end

  always_comb begin
    value_d = value_q;
    lock_d  = lock_q;
    if (wr_accept) begin
      // The lock bit position is never stored; reads show the flag there.
      value_d           = wr_data;
      value_d[LOCK_BIT] = 1'b0;
      lock_d            = lock_q | lock_req;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
      lock_q  <= 1'b0;
    end else begin
      value_q <= value_d;
      lock_q  <= lock_d;
    end
  end

  assign reg_value = value_q;
  assign locked    = lock_q;

endmodule
`default_nettype wire

// File: rtl/lockable_reg_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lockable_reg_bank : bank of write-protected config registers          |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module lockable_reg_bank
  import lockable_reg_pkg::*;
#(
  parameter int                  NUM_REGS = 4,
  parameter int                  DATA_W   = 16,
  parameter int                  ADDR_W   = 2,
  parameter int                  LOCK_BIT = 0,
  parameter logic [2*NUM_REGS-1:0] MODE_VEC = 8'b10_01_00_00,
  parameter int                  CNT_W    = 8
) (
  input  logic                Clk,
  input  logic                ip_reset,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  output logic                wr_ack,
  output logic                wr_err,
  input  logic                lock_all,
  output logic [NUM_REGS-1:0] lock_status,
  output logic [CNT_W-1:0]    viol_count,
  input  logic                viol_clr
);

  localparam logic [MODE_VEC_MAX_W-1:0] MODE_VEC_EXT = MODE_VEC_MAX_W'(MODE_VEC);
  localparam logic [CNT_W-1:0]          CNT_MAX      = {CNT_W{1'b1}};

  logic [NUM_REGS-1:0]             wr_sel;
  logic [NUM_REGS-1:0]             wr_accept;
  logic [NUM_REGS-1:0]             lock_vec;
  logic [NUM_REGS-1:0][DATA_W-1:0] value_vec;

  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              wr_ack_q, wr_ack_d;
  logic              wr_err_q, wr_err_d;
  logic [CNT_W-1:0]  viol_q, viol_d;

  // Out-of-range addresses select no cell, so they fall through to a reject.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_sel[i] = wr_en && (wr_addr == ADDR_W'(i));
    end
  end

  assign wr_accept = wr_sel & ~lock_vec & {NUM_REGS{~lock_all}};

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cells
      lock_reg_cell #(
        .DATA_W   (DATA_W),
        .LOCK_BIT (LOCK_BIT),
        .MODE     (mode_of(MODE_VEC_EXT, gi))
      ) u_cell (
        .clk       (Clk),
        .rst       (ip_reset),
        .wr_accept (wr_accept[gi]),
        .wr_data   (wr_data),
        .reg_value (value_vec[gi]),
        .locked    (lock_vec[gi])
      );
    end
  endgenerate

  always_comb begin
    wr_ack_d = |wr_accept;
    wr_err_d = wr_en && !(|wr_accept);
  end

  // Reads sample the pre-edge register and flag, giving read-before-write.
  always_comb begin
    rd_valid_d = rd_en;
    rd_data_d  = rd_data_q;
    if (rd_en) begin
      rd_data_d = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (rd_addr == ADDR_W'(i)) begin
          rd_data_d           = value_vec[i];
          rd_data_d[LOCK_BIT] = lock_vec[i];
        end
      end
    end
  end

  always_comb begin
    viol_d = viol_q;
    if (viol_clr) begin
      viol_d = wr_err_d ? CNT_W'(1) : '0;
    end else if (wr_err_d && (viol_q != CNT_MAX)) begin
      viol_d = viol_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or posedge ip_reset) begin
    if (ip_reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      wr_ack_q   <= 1'b0;
      wr_err_q   <= 1'b0;
      viol_q     <= '0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      wr_ack_q   <= wr_ack_d;
      wr_err_q   <= wr_err_d;
      viol_q     <= viol_d;
    end
  end

  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign wr_ack      = wr_ack_q;
  assign wr_err      = wr_err_q;
  assign lock_status = lock_vec;
  assign viol_count  = viol_q;

endmodule
`default_nettype wire

// File: tb/tb_lockable_reg_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_lockable_reg_bank : default bank plus a 3-register, 2-bit-counter  |
// | variant driven in lockstep against a behavioural model. rev 1.0      |
// +----------------------------------------------------------------------+
module tb_lockable_reg_bank;

  localparam int LB = 0;

  logic        Clk = 1'b0;
  logic        ip_reset = 1'b0;
  logic        wr_en = 1'b0, rd_en = 1'b0, lock_all = 1'b0, viol_clr = 1'b0;
  logic [1:0]  wr_addr = '0, rd_addr = '0;
  logic [15:0] wr_data = '0;

  logic [15:0] rd_data0, rd_data1;
  logic        rd_valid0, rd_valid1, wr_ack0, wr_ack1, wr_err0, wr_err1;
  logic [3:0]  lock_status0;
  logic [2:0]  lock_status1;
  logic [7:0]  viol_count0;
  logic [1:0]  viol_count1;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  lockable_reg_bank u_dut (
    .Clk(Clk), .ip_reset(ip_reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid0),
    .wr_ack(wr_ack0), .wr_err(wr_err0), .lock_all(lock_all), .lock_status(lock_status0),
    .viol_count(viol_count0), .viol_clr(viol_clr)
  );

  lockable_reg_bank #(.NUM_REGS(3), .ADDR_W(2), .MODE_VEC(6'b01_00_00), .CNT_W(2)) u_dut3 (
    .Clk(Clk), .ip_reset(ip_reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1),
    .wr_ack(wr_ack1), .wr_err(wr_err1), .lock_all(lock_all), .lock_status(lock_status1),
    .viol_count(viol_count1), .viol_clr(viol_clr)
  );

  // Behavioural model: index 0 = default bank, 1 = 3-register variant.
  int          nregs [2] = '{4, 3};
  int          cmax  [2] = '{255, 3};
  int          mode  [2][4] = '{'{0, 0, 1, 2}, '{0, 0, 1, 0}};
  logic [15:0] m_reg [2][4];
  bit          m_lock[2][4];
  int          m_cnt [2];
  logic [15:0] e_rd  [2];
  bit          e_rv[2], e_ack[2], e_err[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        m_reg[k][i]  = '0;
        m_lock[k][i] = 1'b0;
      end
      m_cnt[k] = 0; e_rd[k] = '0; e_rv[k] = 0; e_ack[k] = 0; e_err[k] = 0;
    end
  endtask

  task automatic model_cycle(input bit we, input int wa, input logic [15:0] wd,
                             input bit re, input int ra, input bit la, input bit vc);
    for (int k = 0; k < 2; k++) begin
      bit ok;
      e_rv[k] = re;
      if (re) begin
        if (ra < nregs[k]) begin
          logic [15:0] d;
          d = m_reg[k][ra];
          d[LB] = m_lock[k][ra];
          e_rd[k] = d;
        end else begin
          e_rd[k] = '0;
        end
      end
      ok = we && (wa < nregs[k]) && !m_lock[k][wa] && !la;
      e_ack[k] = ok;
      e_err[k] = we && !ok;
      if (ok) begin
        m_reg[k][wa] = wd;
        m_reg[k][wa][LB] = 1'b0;
        if (mode[k][wa] == 1 || (mode[k][wa] == 2 && wd[LB])) m_lock[k][wa] = 1'b1;
      end
      if (vc) m_cnt[k] = e_err[k] ? 1 : 0;
      else if (e_err[k] && m_cnt[k] < cmax[k]) m_cnt[k] = m_cnt[k] + 1;
    end
  endtask

  function automatic logic [31:0] exp_locks(input int k);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < nregs[k]; i++) v[i] = m_lock[k][i];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string ctx);
    chk({ctx, ":rd_valid0"}, 32'(rd_valid0), 32'(e_rv[0]));
    chk({ctx, ":rd_data0"},  32'(rd_data0),  32'(e_rd[0]));
    chk({ctx, ":wr_ack0"},   32'(wr_ack0),   32'(e_ack[0]));
    chk({ctx, ":wr_err0"},   32'(wr_err0),   32'(e_err[0]));
    chk({ctx, ":locks0"},    32'(lock_status0), exp_locks(0));
    chk({ctx, ":viol0"},     32'(viol_count0),  32'(m_cnt[0]));
    chk({ctx, ":rd_valid1"}, 32'(rd_valid1), 32'(e_rv[1]));
    chk({ctx, ":rd_data1"},  32'(rd_data1),  32'(e_rd[1]));
    chk({ctx, ":wr_ack1"},   32'(wr_ack1),   32'(e_ack[1]));
    chk({ctx, ":wr_err1"},   32'(wr_err1),   32'(e_err[1]));
    chk({ctx, ":locks1"},    32'(lock_status1), exp_locks(1));
    chk({ctx, ":viol1"},     32'(viol_count1),  32'(m_cnt[1]));
  endtask

  task automatic step(input string ctx, input bit we, input int wa, input logic [15:0] wd,
                      input bit re, input int ra, input bit la, input bit vc);
    wr_en = we; wr_addr = 2'(wa); wr_data = wd;
    rd_en = re; rd_addr = 2'(ra); lock_all = la; viol_clr = vc;
    model_cycle(we, wa, wd, re, ra, la, vc);
    @(posedge Clk);
    #1;
    compare_all(ctx);
  endtask

  task automatic idle(input string ctx);
    step(ctx, 0, 0, 16'h0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input string ctx);
    ip_reset = 1'b1;
    wr_en = 0; rd_en = 0; lock_all = 0; viol_clr = 0;
    model_reset();
    @(posedge Clk);
    #1;
    compare_all(ctx);
    @(negedge Clk);
    ip_reset = 1'b0;
  endtask

  initial begin
    model_reset();
    do_reset("reset");
    chk("reset_locks", 32'(lock_status0), 32'h0);

    // Reset readback
    for (int i = 0; i < 4; i++) begin
      step("tp1_read", 0, 0, 16'h0, 1, i, 0, 0);
      chk("tp1_rd_zero", 32'(rd_data0), 32'h0);
      chk("tp1_rd_valid", 32'(rd_valid0), 32'h1);
    end
    idle("tp1_idle");

    // Write-once register
    step("tp2_w1", 1, 2, 16'h1235, 0, 0, 0, 0);
    chk("tp2_ack", 32'(wr_ack0), 32'h1);
    chk("tp2_lock2", 32'(lock_status0[2]), 32'h1);
    step("tp2_w2", 1, 2, 16'hBEEF, 0, 0, 0, 0);
    chk("tp2_err", 32'(wr_err0), 32'h1);
    chk("tp2_viol", 32'(viol_count0), 32'h1);
    step("tp2_rd", 0, 0, 16'h0, 1, 2, 0, 0);
    chk("tp2_rd_val", 32'(rd_data0), 32'h1235);

    // Lock-on-bit register
    step("tp3_w1", 1, 3, 16'h00A0, 0, 0, 0, 0);
    chk("tp3_unlocked", 32'(lock_status0[3]), 32'h0);
    step("tp3_w2", 1, 3, 16'h00A1, 0, 0, 0, 0);
    chk("tp3_locked", 32'(lock_status0[3]), 32'h1);
    step("tp3_w3", 1, 3, 16'hFFFF, 1, 3, 0, 0);
    chk("tp3_rd_locked", 32'(rd_data0), 32'h00A1);
    chk("tp3_err", 32'(wr_err0), 32'h1);
    step("tp3_rd", 0, 0, 16'h0, 1, 3, 0, 0);
    chk("tp3_rd_after", 32'(rd_data0), 32'h00A1);

    // Free register and global lock
    step("tp4_w1", 1, 0, 16'hFFFF, 0, 0, 0, 0);
    step("tp4_rd1", 0, 0, 16'h0, 1, 0, 0, 0);
    chk("tp4_rd_fffe", 32'(rd_data0), 32'hFFFE);
    step("tp4_w_la", 1, 0, 16'h0F0F, 0, 0, 1, 0);
    chk("tp4_err_la", 32'(wr_err0), 32'h1);
    step("tp4_rd2", 0, 0, 16'h0, 1, 0, 0, 0);
    step("tp4_w2", 1, 0, 16'h0F0F, 0, 0, 0, 0);
    step("tp4_rd3", 0, 0, 16'h0, 1, 0, 0, 0);
    chk("tp4_rd_0f0e", 32'(rd_data0), 32'h0F0E);

    // Read-before-write and out-of-range write on the 3-register variant
    step("tp5_w1", 1, 1, 16'h0010, 0, 0, 0, 0);
    step("tp5_rw", 1, 1, 16'h0020, 1, 1, 0, 0);
    chk("tp5_rbw", 32'(rd_data0), 32'h0010);
    step("tp5_rd", 0, 0, 16'h0, 1, 1, 0, 0);
    chk("tp5_new", 32'(rd_data0), 32'h0020);
    step("tp5_oor", 1, 3, 16'h1234, 1, 3, 0, 0);
    chk("tp5_oor_err", 32'(wr_err1), 32'h1);
    chk("tp5_oor_rd", 32'(rd_data1), 32'h0);

    // Counter saturation on the 2-bit variant
    step("tp6_clr", 0, 0, 16'h0, 0, 0, 0, 1);
    chk("tp6_clr0", 32'(viol_count1), 32'h0);
    for (int i = 0; i < 5; i++) step("tp6_rej", 1, 3, 16'h5555, 0, 0, 0, 0);
    chk("tp6_sat", 32'(viol_count1), 32'h3);
    step("tp6_clr_rej", 1, 3, 16'h5555, 0, 0, 0, 1);
    chk("tp6_clr_rej1", 32'(viol_count1), 32'h1);

    // Reset during an in-flight write
    wr_en = 1; wr_addr = 2'd0; wr_data = 16'h4444; rd_en = 1; rd_addr = 2'd0;
    @(posedge Clk);
    #1;
    ip_reset = 1'b1;
    #1;
    model_reset();
    wr_en = 0; rd_en = 0;
    compare_all("mid_reset");
    @(negedge Clk);
    ip_reset = 1'b0;
    idle("post_reset");
    chk("post_reset_ack", 32'(wr_ack0), 32'h0);
    step("post_reset_rd", 0, 0, 16'h0, 1, 0, 0, 0);
    chk("post_reset_rd0", 32'(rd_data0), 32'h0);

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      if (n == 200) do_reset("rand_reset");
      step("rand", ($urandom_range(0, 2) != 0), int'($urandom_range(0, 3)), 16'($urandom),
           ($urandom_range(0, 1) == 1), int'($urandom_range(0, 3)),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 15) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
